milestone1_test: RTL and testbench

MILESTONE1_TEST -- requirements
Module: milestone1_test

---
 rtl/milestone1_test.sv | 93 +++++++++
 tb/tb_milestone1_test.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/milestone1_test.sv
// Soda vending FSM: 20-cent price, credit kept in nickel units, registered dispense/change outputs.
// Optional macro COIN_EDGE_DETECT_EN: coins count only on a 0->1 transition instead of per sampled-high edge.
module milestone1_test (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       dime_i,
    input  logic       nickle_i,
    input  logic       quarter_i,
    output logic       soda_o,
    output logic [2:0] change_o
);

    typedef enum logic [1:0] {
        S0  = 2'd0,
        S5  = 2'd1,
        S10 = 2'd2,
        S15 = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_nk;
    logic       w_dm;
    logic       w_qt;
    logic [3:0] w_credit;
    logic [3:0] w_total;
    logic [3:0] w_excess;
    logic       w_soda_nxt;
    logic [2:0] w_change_nxt;

`ifdef COIN_EDGE_DETECT_EN
    logic r_nk_d;
    logic r_dm_d;
    logic r_qt_d;

    // Previous-cycle coin levels; cleared by reset so a coin held through reset counts once afterwards.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_nk_d <= 1'b0;
            r_dm_d <= 1'b0;
            r_qt_d <= 1'b0;
        end else begin
            r_nk_d <= nickle_i;
            r_dm_d <= dime_i;
            r_qt_d <= quarter_i;
        end
    end

    assign w_nk = nickle_i  & ~r_nk_d;
    assign w_dm = dime_i    & ~r_dm_d;
    assign w_qt = quarter_i & ~r_qt_d;
`else
    assign w_nk = nickle_i;
    assign w_dm = dime_i;
    assign w_qt = quarter_i;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= S0;
            soda_o   <= 1'b0;
            change_o <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            soda_o   <= w_soda_nxt;
            change_o <= w_change_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = S0;
        w_soda_nxt   = 1'b0;
        w_change_nxt = 3'd0;
        case (r_state)
            S0:      w_credit = 4'd0;
            S5:      w_credit = 4'd1;
            S10:     w_credit = 4'd2;
            S15:     w_credit = 4'd3;
            default: w_credit = 4'd0;
        endcase
        // All arithmetic in nickels: max total is 3 + 1 + 2 + 5 = 11.
        w_total  = w_credit + {3'b000, w_nk} + {2'b00, w_dm, 1'b0} + (w_qt ? 4'd5 : 4'd0);
        w_excess = w_total - 4'd4;
        if (w_total >= 4'd4) begin
            w_soda_nxt   = 1'b1;
            w_change_nxt = w_excess[2:0];
            w_state_nxt  = S0;
        end else begin
            w_state_nxt  = state_t'(w_total[1:0]);
        end
    end

endmodule

// File: tb/tb_milestone1_test.sv
// Self-checking bench for milestone1_test: directed scenarios plus random coins against a cents-level model.
module tb_milestone1_test;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       dime_i = 1'b0;
    logic       nickle_i = 1'b0;
    logic       quarter_i = 1'b0;
    logic       soda_o;
    logic [2:0] change_o;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state, in cents.
    int credit = 0;
    int exp_soda = 0;
    int exp_change = 0;
    logic pn = 1'b0, pd = 1'b0, pq = 1'b0;

    milestone1_test dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .dime_i   (dime_i),
        .nickle_i (nickle_i),
        .quarter_i(quarter_i),
        .soda_o   (soda_o),
        .change_o (change_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_out(input string tag);
        check({tag, ".soda"},   int'(soda_o),   exp_soda);
        check({tag, ".change"}, int'(change_o), exp_change);
    endtask

    task automatic model_reset();
        credit = 0; exp_soda = 0; exp_change = 0;
        pn = 1'b0; pd = 1'b0; pq = 1'b0;
    endtask

    // One clock with the given coins; model is updated at the edge, outputs checked 1 time unit later.
    task automatic step(input string tag, input logic n, input logic d, input logic q);
        int v, t;
        logic qn, qd, qq;
        nickle_i = n; dime_i = d; quarter_i = q;
        @(posedge clk_i);
`ifdef COIN_EDGE_DETECT_EN
        qn = n & ~pn; qd = d & ~pd; qq = q & ~pq;
`else
        qn = n; qd = d; qq = q;
`endif
        pn = n; pd = d; pq = q;
        if (rst_i) begin
            v = 5 * int'(qn) + 10 * int'(qd) + 25 * int'(qq);
            t = credit + v;
            if (t >= 20) begin
                exp_soda = 1; exp_change = (t - 20) / 5; credit = 0;
            end else begin
                exp_soda = 0; exp_change = 0; credit = t;
            end
        end else begin
            model_reset();
        end
        #1;
        check_out(tag);
    endtask

    task automatic short_reset();
        #2 rst_i = 1'b0;
        model_reset();
        #1 check_out("async_rst");
        #1 rst_i = 1'b1;
    endtask

    initial begin
        // Reset held with coins toggling.
        #1 check_out("rst_init");
        for (int i = 0; i < 4; i++) step("rst_hold", 1'(i), 1'(i + 1), 1'(i >> 1));
        nickle_i = 0; dime_i = 0; quarter_i = 0;
        #2 rst_i = 1'b1;

        // Mixed coins: dime, idle x2, nickel, idle x3, quarter -> soda, change 4.
        step("mix_d", 0, 1, 0);
        step("mix_i", 0, 0, 0);
        step("mix_i", 0, 0, 0);
        step("mix_n", 1, 0, 0);
        for (int i = 0; i < 3; i++) step("mix_i", 0, 0, 0);
        step("mix_q", 0, 0, 1);
        check("mix_soda_exp", int'(soda_o), 1);
        check("mix_change_exp", int'(change_o), 4);
        step("mix_after", 0, 0, 0);

        // Exact price: two separate dimes.
        step("exact_d1", 0, 1, 0);
        step("exact_i", 0, 0, 0);
        step("exact_d2", 0, 1, 0);
        check("exact_soda_exp", int'(soda_o), 1);
        check("exact_change_exp", int'(change_o), 0);
        step("exact_after", 0, 0, 0);

        // S15 then all three coins -> change 7.
        step("sim_d", 0, 1, 0);
        step("sim_i", 0, 0, 0);
        step("sim_n", 1, 0, 0);
        step("sim_i", 0, 0, 0);
        step("sim_all", 1, 1, 1);
        check("sim_change_exp", int'(change_o), 7);
        step("sim_after", 0, 0, 0);

        // Dime held three cycles (behaviour depends on qualification mode).
        for (int i = 0; i < 3; i++) step("held_d", 0, 1, 0);
        step("held_rel", 0, 0, 0);
        step("held_n", 1, 0, 0);
        step("held_i", 0, 0, 0);
        step("held_d2", 0, 1, 0);
        step("held_i", 0, 0, 0);

        // Reset mid-operation at S15, then a nickel -> S5, no soda.
        step("mid_d", 0, 1, 0);
        step("mid_i", 0, 0, 0);
        step("mid_n", 1, 0, 0);
        step("mid_i", 0, 0, 0);
        short_reset();
        step("mid_n2", 1, 0, 0);
        step("mid_i", 0, 0, 0);
        step("mid_d2", 0, 1, 0);
        step("mid_n3", 1, 0, 0);
        check("mid_soda_exp", int'(soda_o), 1);
        step("mid_i", 0, 0, 0);

        // Random coins with occasional short resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0) short_reset();
            step("rand", 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
